// File: rtl/ara_vcfg_unit.sv
// Vector configuration unit: executes vsetvli/vsetivli/vsetvl, owns the
// architectural vl/vtype state and derives VLMAX from VLEN and the new vtype.
module ara_vcfg_unit #(
  parameter int unsigned VLEN = 4096,
  parameter int unsigned ELEN = 64,
  parameter int unsigned XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [31:0]     req_instr_i,
  input  logic [XLEN-1:0] req_rs1_i,
  input  logic [XLEN-1:0] req_rs2_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_vl_o,
  output logic            resp_illegal_o,
  output logic [XLEN-1:0] csr_vl_o,
  output logic [8:0]      csr_vtype_o,
  output logic            vstart_clr_o
);

  localparam logic [6:0]      OpcodeV   = 7'b1010111;
  localparam logic [2:0]      Funct3Cfg = 3'b111;
  localparam logic [XLEN-1:0] VlenX     = XLEN'(VLEN);
  localparam logic [31:0]     ElenW     = 32'(ELEN);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

  state_e          state_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] rs1_q, rs2_q;
  logic            req_ready_q, resp_valid_q, resp_illegal_q, vstart_clr_q;
  logic [XLEN-1:0] resp_vl_q, csr_vl_q;
  logic [8:0]      csr_vtype_q;

  logic            is_vset, is_vsetivli, keep_vl, use_vlmax, vill;
  logic [4:0]      rs1_idx, rd_idx;
  logic [XLEN-1:0] vtype_raw, avl, base, vlmax;
  logic [2:0]      vsew, vlmul;
  logic [31:0]     sew_bits, elen_frac;
  logic [XLEN-1:0] vl_d;
  logic [8:0]      vtype_d;
  logic            illegal_d;

  always_comb begin
    rs1_idx     = instr_q[19:15];
    rd_idx      = instr_q[11:7];
    is_vset     = 1'b0;
    is_vsetivli = 1'b0;
    vtype_raw   = '0;
    if (instr_q[6:0] == OpcodeV && instr_q[14:12] == Funct3Cfg) begin
      if (!instr_q[31]) begin
        is_vset   = 1'b1;
        vtype_raw = XLEN'(instr_q[30:20]);
      end else if (instr_q[31:30] == 2'b11) begin
        is_vset     = 1'b1;
        is_vsetivli = 1'b1;
        vtype_raw   = XLEN'(instr_q[29:20]);
      end else if (instr_q[31:25] == 7'b1000000) begin
        is_vset   = 1'b1;
        vtype_raw = rs2_q;
      end
    end

    vsew  = vtype_raw[5:3];
    vlmul = vtype_raw[2:0];
    base  = VlenX >> ({1'b0, vsew} + 4'd3);
    if (!vlmul[2]) vlmax = base << vlmul[1:0];
    else           vlmax = base >> (4'd8 - {1'b0, vlmul});

    // Fractional LMUL: the element must fit in ELEN*LMUL bits
    sew_bits  = 32'd8 << vsew;
    elen_frac = ElenW >> (4'd8 - {1'b0, vlmul});

    keep_vl   = !is_vsetivli && rs1_idx == 5'd0 && rd_idx == 5'd0;
    use_vlmax = !is_vsetivli && rs1_idx == 5'd0 && rd_idx != 5'd0;
    avl       = is_vsetivli ? XLEN'(rs1_idx) : rs1_q;

    vill = (vlmul == 3'b100)
        || (sew_bits > ElenW)
        || (|vtype_raw[XLEN-1:8])
        || (vlmul[2] && sew_bits > elen_frac)
        || (keep_vl && csr_vl_q > vlmax);

    illegal_d = !is_vset;
    vl_d      = '0;
    vtype_d   = csr_vtype_q;
    if (is_vset) begin
      if (vill) begin
        vtype_d = {1'b1, 8'b0};
      end else begin
        vtype_d = {1'b0, vtype_raw[7:0]};
        if (keep_vl)        vl_d = csr_vl_q;
        else if (use_vlmax) vl_d = vlmax;
        else                vl_d = (avl < vlmax) ? avl : vlmax;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      instr_q        <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_illegal_q <= 1'b0;
      resp_vl_q      <= '0;
      vstart_clr_q   <= 1'b0;
      csr_vl_q       <= '0;
      csr_vtype_q    <= {1'b1, 8'b0};
    end else begin
      vstart_clr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            instr_q     <= req_instr_i;
            rs1_q       <= req_rs1_i;
            rs2_q       <= req_rs2_i;
            req_ready_q <= 1'b0;
            state_q     <= CALC;
          end
        end
        CALC: begin
          resp_vl_q      <= vl_d;
          resp_illegal_q <= illegal_d;
          resp_valid_q   <= 1'b1;
          if (!illegal_d) begin
            csr_vl_q     <= vl_d;
            csr_vtype_q  <= vtype_d;
            vstart_clr_q <= 1'b1;
          end
          state_q <= RESP;
        end
        RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o    = req_ready_q;
  assign resp_valid_o   = resp_valid_q;
  assign resp_vl_o      = resp_vl_q;
  assign resp_illegal_o = resp_illegal_q;
  assign csr_vl_o       = csr_vl_q;
  assign csr_vtype_o    = csr_vtype_q;
  assign vstart_clr_o   = vstart_clr_q;

endmodule

// File: doc/ara_vcfg_unit.md
Name: ara_vcfg_unit

Overview:
- Parametrised vector-configuration unit for Ara. Executes vsetvli, vsetivli and vsetvl.
- Owns the architectural vl and vtype state and computes VLMAX for any VLEN/ELEN.
- Validates vtype legality, including fractional LMUL and reserved bits, and applies the AVL rules.
- Sits between the dispatcher, which issues requests over a valid/ready handshake, and the lanes and sequencer, which read the vl/vtype outputs.

Parameters:
- VLEN, 4096, vector register length in bits; power of two, at least 128.
- ELEN, 64, maximum element width in bits; one of 8/16/32/64.
- XLEN, 64, scalar register width; width of rs1/rs2/vl.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  unit accepts request
- req_instr_i  in  32  raw instruction
- req_rs1_i  in  XLEN  rs1 value (AVL)
- req_rs2_i  in  XLEN  rs2 value (vtype, vsetvl only)
- resp_valid_o  out  1  result valid
- resp_ready_i  in  1  result consumed
- resp_vl_o  out  XLEN  new vl, written to rd by the dispatcher
- resp_illegal_o  out  1  instruction is not a vset* form
- csr_vl_o  out  XLEN  architectural vl
- csr_vtype_o  out  9  architectural vtype {vill,vma,vta,vsew[2:0],vlmul[2:0]}
- vstart_clr_o  out  1  one-cycle pulse: clear vstart

Behaviour:
- Clock and reset:
  - Single clock clk_i.
  - rst_ni is asynchronous, active-low.
- Reset state:
  - FSM=IDLE, req_ready_o=1, resp_valid_o=0, resp_vl_o=0, resp_illegal_o=0, vstart_clr_o=0.
  - csr_vl_o=0, csr_vtype_o=9'b1_0_0_000_000 (vill=1).
  - Reset mid-operation aborts the instruction and returns all state to these values.
- FSM states:
  - IDLE: req_ready_o=1. On req_valid_i, latch instr/rs1/rs2 and go to CALC.
  - CALC: req_ready_o=0. Decode, check legality, compute VLMAX and vl. Update csr_* on the clock edge leaving CALC. Go to RESP.
  - RESP: resp_valid_o=1; resp_vl_o and resp_illegal_o stay stable. On resp_ready_i go to IDLE.
  - Latency: accept edge to resp_valid_o is 2 cycles.
  - No new request is accepted until the response has completed its handshake.
- Decode (opcode 7'b1010111, func3 3'b111; anything else is illegal):
  - instr[31]=0 -> vsetvli: vtype=zext(instr[30:20]), AVL from rs1.
  - instr[31:30]=11 -> vsetivli: vtype=zext(instr[29:20]), AVL=zext(instr[19:15]).
  - instr[31:25]=1000000 -> vsetvl: vtype=rs2, AVL from rs1.
  - Other encodings -> resp_illegal_o=1, resp_vl_o=0, csr_* unchanged, no vstart_clr_o.
- vill is set when any of the following holds:
  - vlmul=3'b100 (reserved).
  - (8<<vsew) > ELEN.
  - vtype[XLEN-1:8] != 0.
  - Fractional LMUL with SEW > ELEN*LMUL.
  - Keep-vl case where the current vl > new VLMAX.
- On vill:
  - csr_vtype_o = {1,8'b0}, csr_vl_o=0, resp_vl_o=0.
  - resp_illegal_o=0 and vstart_clr_o still pulses.
- VLMAX:
  - base = VLEN >> (3+vsew).
  - vlmul 0..3: VLMAX = base << vlmul.
  - vlmul 5/6/7: VLMAX = base >> (8-vlmul).
  - Result is never 0 for legal vtype.
- AVL selection (rs1 field = instr[19:15], rd field = instr[11:7]; vsetivli always uses uimm):
  - rs1!=x0: AVL = req_rs1_i.
  - rs1==x0 and rd!=x0: vl = VLMAX.
  - rs1==x0 and rd==x0: vl = current csr_vl_o (keep-vl).
- vl rule:
  - vl = min(AVL, VLMAX), compared as unsigned XLEN.
  - AVL=0 gives vl=0.
- vstart_clr_o pulses for exactly one cycle, in the cycle csr_* change, on every decoded vset*.

Test Plan:
- Reset: assert rst_ni=0 asynchronously mid-cycle -> csr_vtype_o=9'h100, csr_vl_o=0, resp_valid_o=0 immediately.
- vsetvli with rs1=x5 holding 1000, e32 m2 (zimm=0x011), VLEN=4096 -> resp_vl_o=256, csr_vtype_o=9'h011, response 2 cycles after accept, vstart_clr_o pulse.
- Fractional LMUL, vsetivli uimm=7:
  - e64 mf2 (zimm=0x01F): SEW 64 > 32 -> csr_vtype_o=9'h100, resp_vl_o=0.
  - e8 mf8 (zimm=0x005): VLMAX=64 -> resp_vl_o=7.
- vsetvl with rs1=x0, rd=x1, rs2=0x018 (e64 m1) -> resp_vl_o=64.
  - Then rs1=x0, rd=x0, rs2=0x012 (e32 m4) -> VLMAX=512, vl kept at 64.
  - Then keep-vl from vl=64 with e64 mf2 under ELEN=64 -> vill.
- Reserved vtype: rs2 bit 63 set, and separately vlmul=4 -> vill; instr func3=3'b000 -> resp_illegal_o=1 with csr_* unchanged.
- Backpressure: hold resp_ready_i=0 for 5 cycles -> resp_valid_o and resp_vl_o stable, req_ready_o=0, second req_valid_i not accepted until the cycle after the response handshake.
